round_scheduler: RTL
====================

// Module: round_scheduler
// PURPOSE
// - Sequences play while game_control_fsm is in GAME_RUNNING: rounds, duck spawns, round timer, hit tally.
// - Drives the spawn handshake of the duck generator and returns game_finished to game_control_fsm.
// - Keeps hits/round_num after the game so the end screen can show them.
// PARAMETERS
// CLK_FREQ_HZ      65_000_000  clk frequency; 1 ms tick = CLK_FREQ_HZ/1000 cycles
// ROUNDS           5           rounds per game (1..7)
// DUCKS_PER_ROUND  10          spawns per round (1..15)
// ROUND_TIME_S     30          round time limit in seconds (1..63)
// SPAWN_GAP_MS     500         delay before each spawn request (>=1)
// ROUND_PAUSE_MS   2000        pause between rounds (>=1)
// PORTS
// clk                  in   1  system clock
// rst                  in   1  reset, asynchronous, active-high
// game_enable          in   1  level from game_control_fsm; high = game running
// game_enable_posedge  in   1  1-cycle start pulse from game_control_fsm
// duck_hit             in   1  1-cycle pulse: in-flight duck shot
// duck_escaped         in   1  1-cycle pulse: in-flight duck left screen
// spawn_ack            in   1  duck generator accepted spawn_req
// spawn_req            out  1  request one duck; held until spawn_ack
// round_num            out  3  current round, 1-based (0 before first start)
// ducks_left           out  4  spawns still to issue this round
// time_left_s          out  6  seconds left in round
// hits                 out  8  total hits this game, saturates at 255
// round_pause          out  1  high during inter-round pause
// game_finished        out  1  high in DONE
// BEHAVIOUR
// - Reset (async): state=IDLE; every output 0; ms/second prescalers 0.
// - States: IDLE, GAP, SPAWN, FLY, PAUSE, DONE.
// - IDLE: outputs hold. game_enable_posedge -> round_num=1, ducks_left=DUCKS_PER_ROUND,
//   time_left_s=ROUND_TIME_S, hits=0, gap counter=0, second prescaler=0 -> GAP.
// - GAP: count ms ticks; at gap length -> SPAWN.
// - SPAWN: spawn_req=1. spawn_ack -> spawn_req=0 next cycle, ducks_left-1, -> FLY.
// - FLY: duck_hit -> hits+1 (sat 255); duck_hit or duck_escaped -> GAP if ducks_left>0 else PAUSE.
//   duck_hit and duck_escaped together count as a hit.
// - Round timer: 1 s tick, active only in GAP/SPAWN/FLY; time_left_s decrements.
//   At 0 -> PAUSE immediately; spawn_req drops; remaining ducks forfeited; in-flight duck not scored.
// - PAUSE: round_pause=1 for ROUND_PAUSE_MS.
//   Then round_num<ROUNDS: round_num+1, ducks_left and time_left_s reloaded -> GAP.
//   Otherwise -> DONE.
// - DONE: game_finished=1 (level) until game_enable=0.
// - game_enable=0 in any non-IDLE state -> IDLE next cycle: spawn_req=0, game_finished=0.
//   Counters keep their values (end screen reads hits).
// - duck_hit/duck_escaped outside FLY are ignored. spawn_ack outside SPAWN is ignored.
// - Latency: spawn_req rises 1 cycle after the gap ends; no combinational input->output paths.
// CONFIGURATION
// - ROUND_SPEEDUP_EN defined: gap in round r = SPAWN_GAP_MS >> (r-1), floor 1 ms.
// - ROUND_SPEEDUP_EN undefined: gap = SPAWN_GAP_MS in every round.
// TESTING (CLK_FREQ_HZ=1000 so 1 ms = 1 cycle; ROUNDS=2, DUCKS_PER_ROUND=3, ROUND_TIME_S=5,
//          SPAWN_GAP_MS=4, ROUND_PAUSE_MS=3)
// - Reset mid-SPAWN -> spawn_req, round_num, hits, game_finished all 0 asynchronously.
// - Start pulse, ack each request after 2 cycles, hit every duck ->
//   6 spawn_req pulses, hits=6, round_num 1->2, round_pause high 3 cycles, game_finished=1.
// - Never ack in round 1 -> time_left_s 5..0, spawn_req drops at expiry, round 2 starts with ducks_left=3.
// - duck_hit and duck_escaped in the same FLY cycle -> hits+1.
//   Same pulses in GAP -> hits unchanged.
// - game_enable low during FLY -> IDLE next cycle; hits held; new start pulse clears hits to 0.
// - ROUND_SPEEDUP_EN: round 2 gap = 2 cycles vs 4 in round 1.
//   Undefined: 4 cycles in both rounds.

Source files
------------

// File: rtl/round_scheduler.sv
// -----------------------------------------------------------------------------
// round_scheduler
//
// Purpose:
//   Sequences play while the game controller reports a running game: rounds,
//   duck spawns, the per-round countdown and the hit tally. It drives the spawn
//   handshake of the duck generator and reports game completion back to the
//   game controller. hits/round_num survive the end of a game so the end
//   screen can show them.
//
// Optional feature (compile-time macro):
//   ROUND_SPEEDUP_EN  defined   -> spawn gap in round r = SPAWN_GAP_MS >> (r-1),
//                                  never shorter than 1 ms.
//                     undefined -> spawn gap = SPAWN_GAP_MS in every round.
//
// Ports:
//   i_clk                  system clock
//   i_rst                  asynchronous active-high reset
//   i_game_enable          level, high while the game is running
//   i_game_enable_posedge  1-cycle start pulse
//   i_duck_hit             1-cycle pulse, in-flight duck shot
//   i_duck_escaped         1-cycle pulse, in-flight duck left the screen
//   i_spawn_ack            duck generator accepted o_spawn_req
//   o_spawn_req            request one duck, held until i_spawn_ack
//   o_round_num   [2:0]    current round, 1-based (0 before first start)
//   o_ducks_left  [3:0]    spawns still to issue this round
//   o_time_left_s [5:0]    seconds left in the round
//   o_hits        [7:0]    hits this game, saturating at 255
//   o_round_pause          high during the inter-round pause
//   o_game_finished        high once all rounds are played
//
// All outputs come straight from registers; there is no combinational path
// from any input to any output.
// -----------------------------------------------------------------------------
module round_scheduler #(
  parameter int unsigned CLK_FREQ_HZ     = 65_000_000,
  parameter int unsigned ROUNDS          = 5,
  parameter int unsigned DUCKS_PER_ROUND = 10,
  parameter int unsigned ROUND_TIME_S    = 30,
  parameter int unsigned SPAWN_GAP_MS    = 500,
  parameter int unsigned ROUND_PAUSE_MS  = 2000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_game_enable,
  input  logic       i_game_enable_posedge,
  input  logic       i_duck_hit,
  input  logic       i_duck_escaped,
  input  logic       i_spawn_ack,
  output logic       o_spawn_req,
  output logic [2:0] o_round_num,
  output logic [3:0] o_ducks_left,
  output logic [5:0] o_time_left_s,
  output logic [7:0] o_hits,
  output logic       o_round_pause,
  output logic       o_game_finished
);

  // Clock cycles per millisecond; clamped so a slow test clock still ticks.
  localparam int unsigned MS_CYCLES = (CLK_FREQ_HZ / 1000 < 1) ? 1 : (CLK_FREQ_HZ / 1000);
  localparam logic [31:0] MS_LAST   = 32'(MS_CYCLES - 1);
  localparam logic [31:0] PAUSE_LEN = 32'(ROUND_PAUSE_MS);
  localparam logic [2:0]  ROUNDS_C  = 3'(ROUNDS);
  localparam logic [3:0]  DUCKS_C   = 4'(DUCKS_PER_ROUND);
  localparam logic [5:0]  TIME_C    = 6'(ROUND_TIME_S);
  localparam logic [9:0]  SEC_LAST  = 10'd999;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_SPAWN,
    S_FLY,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [31:0] r_ms_cnt;
  logic [9:0]  r_sec_cnt;
  logic [31:0] r_phase_cnt;   // ms elapsed in GAP or PAUSE (the two never overlap)
  logic        r_spawn_req;
  logic [2:0]  r_round_num;
  logic [3:0]  r_ducks_left;
  logic [5:0]  r_time_left;
  logic [7:0]  r_hits;
  logic        r_round_pause;
  logic        r_game_finished;

  state_t      w_state_next;
  logic [31:0] w_ms_cnt_next;
  logic [9:0]  w_sec_cnt_next;
  logic [31:0] w_phase_cnt_next;
  logic        w_spawn_req_next;
  logic [2:0]  w_round_num_next;
  logic [3:0]  w_ducks_left_next;
  logic [5:0]  w_time_left_next;
  logic [7:0]  w_hits_next;
  logic        w_round_pause_next;
  logic        w_game_finished_next;

  logic        w_ms_tick;
  logic        w_active;
  logic        w_sec_tick;
  logic        w_expire;
  logic [31:0] w_gap_len;
  logic [31:0] w_phase_inc;

  // ---------------------------------------------------------------------------
  // Gap length for the current round
  // ---------------------------------------------------------------------------
`ifdef ROUND_SPEEDUP_EN
  logic [31:0] w_gap_shifted;
  // Round numbers are 1-based, so round 1 uses the full gap.
  assign w_gap_shifted = 32'(SPAWN_GAP_MS) >> (r_round_num - 3'd1);
  assign w_gap_len     = (w_gap_shifted == 32'd0) ? 32'd1 : w_gap_shifted;
`else
  assign w_gap_len = 32'(SPAWN_GAP_MS);
`endif

  // ---------------------------------------------------------------------------
  // Timebase
  // ---------------------------------------------------------------------------
  assign w_ms_tick   = (r_ms_cnt == MS_LAST);
  // The round clock only runs while ducks are being served.
  assign w_active    = (r_state == S_GAP) || (r_state == S_SPAWN) || (r_state == S_FLY);
  assign w_sec_tick  = w_active && w_ms_tick && (r_sec_cnt == SEC_LAST);
  // Expiry is taken on the tick that would bring the counter to zero.
  assign w_expire    = w_sec_tick && (r_time_left <= 6'd1);
  assign w_phase_inc = r_phase_cnt + 32'd1;

  // ---------------------------------------------------------------------------
  // State / datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_ms_cnt        <= '0;
      r_sec_cnt       <= '0;
      r_phase_cnt     <= '0;
      r_spawn_req     <= 1'b0;
      r_round_num     <= '0;
      r_ducks_left    <= '0;
      r_time_left     <= '0;
      r_hits          <= '0;
      r_round_pause   <= 1'b0;
      r_game_finished <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_ms_cnt        <= w_ms_cnt_next;
      r_sec_cnt       <= w_sec_cnt_next;
      r_phase_cnt     <= w_phase_cnt_next;
      r_spawn_req     <= w_spawn_req_next;
      r_round_num     <= w_round_num_next;
      r_ducks_left    <= w_ducks_left_next;
      r_time_left     <= w_time_left_next;
      r_hits          <= w_hits_next;
      r_round_pause   <= w_round_pause_next;
      r_game_finished <= w_game_finished_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next         = r_state;
    w_ms_cnt_next        = w_ms_tick ? 32'd0 : (r_ms_cnt + 32'd1);
    w_sec_cnt_next       = r_sec_cnt;
    w_phase_cnt_next     = r_phase_cnt;
    w_spawn_req_next     = r_spawn_req;
    w_round_num_next     = r_round_num;
    w_ducks_left_next    = r_ducks_left;
    w_time_left_next     = r_time_left;
    w_hits_next          = r_hits;
    w_round_pause_next   = r_round_pause;
    w_game_finished_next = r_game_finished;

    if (w_active && w_ms_tick) begin
      w_sec_cnt_next = (r_sec_cnt == SEC_LAST) ? 10'd0 : (r_sec_cnt + 10'd1);
    end

    if ((r_state != S_IDLE) && !i_game_enable) begin
      // Abort: counters are left alone so the end screen can still read them.
      w_state_next         = S_IDLE;
      w_spawn_req_next     = 1'b0;
      w_round_pause_next   = 1'b0;
      w_game_finished_next = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_game_enable_posedge) begin
            w_state_next      = S_GAP;
            w_round_num_next  = 3'd1;
            w_ducks_left_next = DUCKS_C;
            w_time_left_next  = TIME_C;
            w_hits_next       = 8'd0;
            w_phase_cnt_next  = 32'd0;
            w_sec_cnt_next    = 10'd0;
          end
        end

        S_GAP, S_SPAWN, S_FLY: begin
          if (w_sec_tick) begin
            w_time_left_next = r_time_left - 6'd1;
          end
          if (w_expire) begin
            // Time is up: any pending request is withdrawn, remaining ducks are
            // forfeited and a duck still in flight earns nothing.
            w_state_next       = S_PAUSE;
            w_time_left_next   = 6'd0;
            w_spawn_req_next   = 1'b0;
            w_round_pause_next = 1'b1;
            w_phase_cnt_next   = 32'd0;
          end else begin
            case (r_state)
              S_GAP: begin
                if (w_ms_tick) begin
                  if (w_phase_inc >= w_gap_len) begin
                    w_state_next     = S_SPAWN;
                    w_spawn_req_next = 1'b1;
                    w_phase_cnt_next = 32'd0;
                  end else begin
                    w_phase_cnt_next = w_phase_inc;
                  end
                end
              end
              S_SPAWN: begin
                if (i_spawn_ack) begin
                  w_state_next      = S_FLY;
                  w_spawn_req_next  = 1'b0;
                  w_ducks_left_next = r_ducks_left - 4'd1;
                end
              end
              default: begin  // S_FLY
                if (i_duck_hit || i_duck_escaped) begin
                  // A simultaneous hit and escape is scored as a hit.
                  if (i_duck_hit && (r_hits != 8'hFF)) begin
                    w_hits_next = r_hits + 8'd1;
                  end
                  w_phase_cnt_next = 32'd0;
                  if (r_ducks_left != 4'd0) begin
                    w_state_next = S_GAP;
                  end else begin
                    w_state_next       = S_PAUSE;
                    w_round_pause_next = 1'b1;
                  end
                end
              end
            endcase
          end
        end

        S_PAUSE: begin
          if (w_ms_tick) begin
            if (w_phase_inc >= PAUSE_LEN) begin
              w_round_pause_next = 1'b0;
              w_phase_cnt_next   = 32'd0;
              if (r_round_num < ROUNDS_C) begin
                w_state_next      = S_GAP;
                w_round_num_next  = r_round_num + 3'd1;
                w_ducks_left_next = DUCKS_C;
                w_time_left_next  = TIME_C;
                w_sec_cnt_next    = 10'd0;
              end else begin
                w_state_next         = S_DONE;
                w_game_finished_next = 1'b1;
              end
            end else begin
              w_phase_cnt_next = w_phase_inc;
            end
          end
        end

        S_DONE: begin
          // Held until game_enable falls (handled by the abort path above).
        end

        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  assign o_spawn_req     = r_spawn_req;
  assign o_round_num     = r_round_num;
  assign o_ducks_left    = r_ducks_left;
  assign o_time_left_s   = r_time_left;
  assign o_hits          = r_hits;
  assign o_round_pause   = r_round_pause;
  assign o_game_finished = r_game_finished;

endmodule
